// File: rtl/if_id_buffer.sv
// IF/ID pipeline register for a Thumb fetch stream.
// Captures one 16-bit halfword per cycle and presents a registered instruction and PC to decode.
// BL prefix/suffix halfwords are paired into a single 32-bit packet. An orphaned prefix is emitted
// alone, flagged bad_pair_o, and the halfword that broke the pair is replayed the next cycle.
// Stall holds all state; flush discards any buffered prefix and replay entry.
// Optional: define IF_ID_PERF_CNT_EN to add a saturating bubble counter (bubble_count_o).
module if_id_buffer #(
  parameter int unsigned WORD = 32,
  parameter int unsigned HALF = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [WORD-1:0] program_counter_i,
  input  logic            pc_valid_i,
  input  logic [HALF-1:0] instr_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic [WORD-1:0] instr_o,
  output logic [WORD-1:0] instr_pc_o,
  output logic            is_32bit_o,
  output logic            valid_o,
`ifdef IF_ID_PERF_CNT_EN
  output logic [WORD-1:0] bubble_count_o,
`endif
  output logic            bad_pair_o
);

  typedef enum logic {StIdle, StHavePrefix} state_e;

  state_e          state_q, state_d;
  logic [HALF-1:0] prefix_q, prefix_d;
  logic [WORD-1:0] prefix_pc_q, prefix_pc_d;
  logic            replay_valid_q, replay_valid_d;
  logic [HALF-1:0] replay_instr_q, replay_instr_d;
  logic [WORD-1:0] replay_pc_q, replay_pc_d;
  logic            valid_q, valid_d;
  logic [WORD-1:0] instr_q, instr_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic            is_32bit_q, is_32bit_d;
  logic            bad_pair_q, bad_pair_d;

  // Effective input: an occupied replay slot takes priority and masks the fetch port.
  logic            eff_valid;
  logic [HALF-1:0] eff_instr;
  logic [WORD-1:0] eff_pc;
  logic            consume;
  logic            eff_is_prefix;
  logic            eff_is_suffix;

  // Select the halfword to process this cycle and decode its BL role.
  always_comb begin
    eff_valid     = replay_valid_q | pc_valid_i;
    eff_instr     = replay_valid_q ? replay_instr_q : instr_i;
    eff_pc        = replay_valid_q ? replay_pc_q : program_counter_i;
    consume       = eff_valid & ~stall_i & ~flush_i;
    eff_is_prefix = (eff_instr[HALF-1 -: 5] == 5'b11110);
    eff_is_suffix = (eff_instr[HALF-1 -: 5] == 5'b11111);
  end

  // Next-state for the pairing FSM, the buffered prefix, the replay slot and the output packet.
  always_comb begin
    state_d        = state_q;
    prefix_d       = prefix_q;
    prefix_pc_d    = prefix_pc_q;
    replay_valid_d = replay_valid_q;
    replay_instr_d = replay_instr_q;
    replay_pc_d    = replay_pc_q;
    valid_d        = valid_q;
    instr_d        = instr_q;
    pc_d           = pc_q;
    is_32bit_d     = is_32bit_q;
    bad_pair_d     = bad_pair_q;

    if (flush_i) begin
      state_d        = StIdle;
      prefix_d       = '0;
      prefix_pc_d    = '0;
      replay_valid_d = 1'b0;
      valid_d        = 1'b0;
      is_32bit_d     = 1'b0;
      bad_pair_d     = 1'b0;
    end else if (stall_i) begin
      // Hold everything so decode re-samples the same packet.
    end else if (!consume) begin
      valid_d = 1'b0;
    end else begin
      replay_valid_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (eff_is_prefix) begin
            prefix_d    = eff_instr;
            prefix_pc_d = eff_pc;
            state_d     = StHavePrefix;
            valid_d     = 1'b0;
          end else begin
            valid_d    = 1'b1;
            instr_d    = WORD'(eff_instr);
            pc_d       = eff_pc;
            is_32bit_d = 1'b0;
            bad_pair_d = 1'b0;
          end
        end
        StHavePrefix: begin
          state_d = StIdle;
          valid_d = 1'b1;
          pc_d    = prefix_pc_q;
          if (eff_is_suffix) begin
            instr_d    = WORD'({prefix_q, eff_instr});
            is_32bit_d = 1'b1;
            bad_pair_d = 1'b0;
          end else begin
            // Orphaned prefix: emit it alone and park the breaking halfword for next cycle.
            instr_d        = WORD'(prefix_q);
            is_32bit_d     = 1'b0;
            bad_pair_d     = 1'b1;
            replay_valid_d = 1'b1;
            replay_instr_d = eff_instr;
            replay_pc_d    = eff_pc;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q        <= StIdle;
      prefix_q       <= '0;
      prefix_pc_q    <= '0;
      replay_valid_q <= 1'b0;
      replay_instr_q <= '0;
      replay_pc_q    <= '0;
      valid_q        <= 1'b0;
      instr_q        <= '0;
      pc_q           <= '0;
      is_32bit_q     <= 1'b0;
      bad_pair_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      prefix_q       <= prefix_d;
      prefix_pc_q    <= prefix_pc_d;
      replay_valid_q <= replay_valid_d;
      replay_instr_q <= replay_instr_d;
      replay_pc_q    <= replay_pc_d;
      valid_q        <= valid_d;
      instr_q        <= instr_d;
      pc_q           <= pc_d;
      is_32bit_q     <= is_32bit_d;
      bad_pair_q     <= bad_pair_d;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic            bubble;
  logic [WORD-1:0] bubble_cnt_q, bubble_cnt_d;

  // A bubble is any non-stalled edge that writes valid_o low: flush, prefix capture or idle fetch.
  always_comb begin
    bubble = flush_i |
             (~stall_i & (~consume | ((state_q == StIdle) & eff_is_prefix)));
    bubble_cnt_d = bubble_cnt_q;
    if (bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  // Saturating bubble counter register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_count_o = bubble_cnt_q;
`endif

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign instr_pc_o = pc_q;
  assign is_32bit_o = is_32bit_q;
  assign bad_pair_o = bad_pair_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: a queue-based reference model predicts decode packets,
// a negedge monitor pops and compares whenever the DUT presents a new packet.
module tb_if_id_buffer;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_valid;
  logic [15:0] instr;
  logic        stall;
  logic        flush;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        is_32bit_o;
  logic        valid_o;
  logic        bad_pair_o;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] bubble_count_o;
`endif

  if_id_buffer #(.WORD(32), .HALF(16)) dut (
    .clk_i             (clk),
    .reset_i           (rst_n),
    .program_counter_i (pc),
    .pc_valid_i        (pc_valid),
    .instr_i           (instr),
    .stall_i           (stall),
    .flush_i           (flush),
    .instr_o           (instr_o),
    .instr_pc_o        (instr_pc_o),
    .is_32bit_o        (is_32bit_o),
    .valid_o           (valid_o),
`ifdef IF_ID_PERF_CNT_EN
    .bubble_count_o    (bubble_count_o),
`endif
    .bad_pair_o        (bad_pair_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is32;
    logic        bad;
  } pkt_t;

  typedef struct {
    logic [15:0] h;
    logic [31:0] pc;
  } hw_t;

  pkt_t exp_q[$];
  hw_t  held_q[$];
  hw_t  replay_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_bubbles = 0;

  pkt_t last;
  logic last_valid = 1'b0;
  logic mon_en = 1'b0;
  logic e_stall = 1'b0;
  logic e_flush = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_pfx(input logic [15:0] h);
    return h[15:11] == 5'b11110;
  endfunction

  function automatic logic is_sfx(input logic [15:0] h);
    return h[15:11] == 5'b11111;
  endfunction

  // Reference model: halfword stream in, decode packets out.
  task automatic model_step(input logic v, input logic [31:0] p, input logic [15:0] h,
                            input logic s, input logic f);
    hw_t  hw;
    hw_t  pr;
    pkt_t pk;
    logic have;
    if (f) begin
      held_q.delete();
      replay_q.delete();
      model_bubbles++;
    end else if (!s) begin
      have = 1'b0;
      if (replay_q.size() > 0) begin
        hw = replay_q.pop_front();
        have = 1'b1;
      end else if (v) begin
        hw.h = h;
        hw.pc = p;
        have = 1'b1;
      end
      if (!have) begin
        model_bubbles++;
      end else if (held_q.size() > 0) begin
        pr = held_q.pop_front();
        pk.pc = pr.pc;
        if (is_sfx(hw.h)) begin
          pk.instr = {pr.h, hw.h};
          pk.is32 = 1'b1;
          pk.bad = 1'b0;
        end else begin
          pk.instr = {16'h0, pr.h};
          pk.is32 = 1'b0;
          pk.bad = 1'b1;
          replay_q.push_back(hw);
        end
        exp_q.push_back(pk);
      end else if (is_pfx(hw.h)) begin
        held_q.push_back(hw);
        model_bubbles++;
      end else begin
        pk.instr = {16'h0, hw.h};
        pk.pc = hw.pc;
        pk.is32 = 1'b0;
        pk.bad = 1'b0;
        exp_q.push_back(pk);
      end
    end
  endtask

  // Apply inputs for the next edge, predict its effect, then wait past that edge.
  task automatic drive(input logic v, input logic [31:0] p, input logic [15:0] h,
                       input logic s, input logic f);
    pc_valid = v;
    pc = p;
    instr = h;
    stall = s;
    flush = f;
    model_step(v, p, h, s, f);
    @(posedge clk);
    #1;
  endtask

  // Record the control inputs seen by each edge for the monitor.
  always @(posedge clk) begin
    e_stall = stall;
    e_flush = flush;
  end

  // Monitor: stalled edges must hold the packet; otherwise each valid packet pops one prediction.
  always @(negedge clk) begin
    pkt_t got;
    if (mon_en) begin
      if (e_stall && !e_flush) begin
        check("stall_hold_valid", {31'h0, valid_o}, {31'h0, last_valid});
        if (last_valid) begin
          check("stall_hold_instr", instr_o, last.instr);
          check("stall_hold_pc", instr_pc_o, last.pc);
        end
      end else if (valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_packet_instr", instr_o, 32'hxxxx_xxxx);
          last_valid = 1'b0;
        end else begin
          got = exp_q.pop_front();
          check("pkt_instr", instr_o, got.instr);
          check("pkt_pc", instr_pc_o, got.pc);
          check("pkt_is32", {31'h0, is_32bit_o}, {31'h0, got.is32});
          check("pkt_bad", {31'h0, bad_pair_o}, {31'h0, got.bad});
          last = got;
          last_valid = 1'b1;
        end
      end else begin
        last_valid = 1'b0;
        if (e_flush) begin
          check("flush_is32", {31'h0, is_32bit_o}, 32'h0);
          check("flush_bad", {31'h0, bad_pair_o}, 32'h0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'h0, valid_o}, 32'h0);
    check({tag, "_instr"}, instr_o, 32'h0);
    check({tag, "_pc"}, instr_pc_o, 32'h0);
    check({tag, "_is32"}, {31'h0, is_32bit_o}, 32'h0);
    check({tag, "_bad"}, {31'h0, bad_pair_o}, 32'h0);
`ifdef IF_ID_PERF_CNT_EN
    check({tag, "_bubbles"}, bubble_count_o, 32'h0);
`endif
  endtask

  initial begin
    logic [31:0] rpc;
    logic [15:0] rh;
    int          r;
    rst_n = 1'b0;
    pc = '0;
    pc_valid = 1'b0;
    instr = '0;
    stall = 1'b0;
    flush = 1'b0;
    #3;
    check_reset_outputs("reset");
    #9;
    rst_n = 1'b1;
    mon_en = 1'b1;
    drive(1'b0, 32'd0, 16'h0, 1'b0, 1'b0);

    // Plain 16-bit stream.
    drive(1'b1, 32'd0, 16'h2001, 1'b0, 1'b0);
    drive(1'b1, 32'd2, 16'h3002, 1'b0, 1'b0);
    // BL pair.
    drive(1'b1, 32'd4, 16'hF000, 1'b0, 1'b0);
    drive(1'b1, 32'd6, 16'hF802, 1'b0, 1'b0);
    // Orphan prefix; the replay cycle must ignore the fetch port.
    drive(1'b1, 32'd8, 16'hF000, 1'b0, 1'b0);
    drive(1'b1, 32'd10, 16'h2005, 1'b0, 1'b0);
    drive(1'b1, 32'd12, 16'h1111, 1'b0, 1'b0);
    // Three-cycle stall holding a packet.
    drive(1'b1, 32'd12, 16'h2001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'd14, 16'h2002, 1'b1, 1'b0);
    drive(1'b1, 32'd14, 16'h2002, 1'b0, 1'b0);
    // Prefix split by a flush (with stall) never pairs afterwards.
    drive(1'b1, 32'd12, 16'hF000, 1'b0, 1'b0);
    drive(1'b1, 32'd14, 16'hF802, 1'b1, 1'b1);
    drive(1'b1, 32'd40, 16'hF802, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 16'h0, 1'b0, 1'b0);

    // Randomized stream.
    rpc = 32'h100;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 9);
      rh = 16'($urandom);
      if (r < 3) rh[15:11] = 5'b11110;
      else if (r < 5) rh[15:11] = 5'b11111;
      drive(($urandom_range(0, 9) < 8), rpc, rh, ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 8));
      rpc = rpc + 32'd2;
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 32'd0, 16'h0, 1'b0, 1'b0);
    check("drain_pending", exp_q.size(), 32'd0);

    // Async reset in the middle of HAVE_PREFIX.
    drive(1'b0, 32'd0, 16'h0, 1'b0, 1'b1);
    drive(1'b1, 32'd100, 16'h2003, 1'b0, 1'b0);
    drive(1'b1, 32'd102, 16'hF123, 1'b0, 1'b0);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    held_q.delete();
    replay_q.delete();
    model_bubbles = 0;
    last_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    mon_en = 1'b1;
    drive(1'b1, 32'd0, 16'hF000, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 16'h0, 1'b0, 1'b1);
`ifdef IF_ID_PERF_CNT_EN
    check("bubble_count", bubble_count_o, model_bubbles);
`endif
    drive(1'b1, 32'd50, 16'hF805, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 16'h0, 1'b0, 1'b0);
    check("final_pending", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
